nukv_fifo_feeder: RTL and testbench

Write-side feeder for the NUKV synchronous FIFO. The FIFO's write port has no backpressure: every cycle with write-valid high is a write. It only reports a programmable almost-full flag at depth−8. This block accepts a standard valid/ready stream from upstream logic, registers it through a fixed-latency pipeline, and drives the FIFO write port. It throttles upstream from the registered almost-full flag with resume hysteresis, so no write ever lands on a full FIFO.

---
 rtl/nukv_fifo_feeder.sv | 115 +++++++++++
 tb/tb_nukv_fifo_feeder.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/nukv_fifo_feeder.sv
// Write-side feeder for the NUKV synchronous FIFO: valid/ready upstream, fixed-latency
// pipeline to a no-backpressure write port, almost-full throttle with resume hysteresis.
// Optional statistics are built when NUKV_FEEDER_STATS_EN is defined.
module nukv_fifo_feeder #(
  parameter int DATA_SIZE     = 16,
  parameter int PIPE_STAGES   = 1,
  parameter int SLACK         = 8,
  parameter int RESUME_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_SIZE-1:0] s_axis_tdata,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  output logic [DATA_SIZE-1:0] m_axis_tdata,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  input  logic                 m_axis_talmostfull,
  output logic [31:0]          stat_words,
  output logic                 stat_overflow
);

  // Worst case is PIPE_STAGES+2 writes after almost-full rises; they must fit in the slack.
  if (PIPE_STAGES < 1 || PIPE_STAGES + 2 > SLACK) begin : g_bad_slack
    $error("nukv_fifo_feeder: need 1 <= PIPE_STAGES and PIPE_STAGES+2 <= SLACK");
  end
  if (RESUME_CYCLES < 0 || RESUME_CYCLES > 15) begin : g_bad_resume
    $error("nukv_fifo_feeder: RESUME_CYCLES must be in 0..15");
  end

  localparam logic       HOLD       = 1'b0;
  localparam logic       RUN        = 1'b1;
  localparam logic [3:0] RESUME_CNT = RESUME_CYCLES[3:0];

  logic       state;
  logic [3:0] cnt;
  logic       afull_q;
  logic       accept;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would let afull_q leak into the FSM in one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      afull_q <= 1'b1;
      state   <= HOLD;
      cnt     <= '0;
    end else begin
      afull_q <= m_axis_talmostfull;
      if (state == RUN) begin
        if (afull_q) begin
          state <= HOLD;
          cnt   <= '0;
        end
      end else begin
        if (afull_q) begin
          cnt <= '0;
        end else if (cnt != RESUME_CNT) begin
          cnt <= cnt + 4'd1;
        end else begin
          state <= RUN;
        end
      end
    end
  end

  assign s_axis_tready = (state == RUN);
  assign accept        = s_axis_tvalid & s_axis_tready;

  logic [PIPE_STAGES-1:0] vld_q;
  logic [DATA_SIZE-1:0]   dat_q [PIPE_STAGES];

  // NOTE: the data registers are reset too, because m_axis_tdata has a defined reset
  // value; a pure storage array with no observable reset value would be left unreset.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      for (int i = 0; i < PIPE_STAGES; i++) dat_q[i] <= '0;
    end else begin
      vld_q[0] <= accept;
      if (accept) dat_q[0] <= s_axis_tdata;
      for (int i = 1; i < PIPE_STAGES; i++) begin
        vld_q[i] <= vld_q[i-1];
        dat_q[i] <= dat_q[i-1];
      end
    end
  end

  assign m_axis_tvalid = vld_q[PIPE_STAGES-1];
  assign m_axis_tdata  = dat_q[PIPE_STAGES-1];

`ifdef NUKV_FEEDER_STATS_EN
  logic [31:0] words_q;
  logic        overflow_q;

  // An overflowing write still goes out but is not counted as a successful word.
  always_ff @(posedge clk) begin
    if (rst) begin
      words_q    <= '0;
      overflow_q <= 1'b0;
    end else if (m_axis_tvalid) begin
      if (m_axis_tready) words_q <= words_q + 32'd1;
      else               overflow_q <= 1'b1;
    end
  end

  assign stat_words    = words_q;
  assign stat_overflow = overflow_q;
`else
  logic unused_tready;
  assign unused_tready = m_axis_tready;
  assign stat_words    = '0;
  assign stat_overflow = 1'b0;
`endif

endmodule

// File: tb/tb_nukv_fifo_feeder.sv
// Self-checking bench for nukv_fifo_feeder: PIPE_STAGES=1 and =2 instances share stimulus
// and are compared every cycle against a streak/schedule reference model.
module tb_nukv_fifo_feeder;
  localparam int DW = 16;
  localparam int R  = 4;
  localparam int P0 = 1;
  localparam int P1 = 2;

  logic          clk = 1'b0;
  logic          rst, s_valid, m_ready, afull;
  logic [DW-1:0] s_data;
  logic          rdy0, mv0, so0, rdy1, mv1, so1;
  logic [DW-1:0] md0, md1;
  logic [31:0]   sw0, sw1;

  always #5 clk = ~clk;

  nukv_fifo_feeder #(.DATA_SIZE(DW), .PIPE_STAGES(P0), .SLACK(8), .RESUME_CYCLES(R)) u_dut0 (
    .clk(clk), .rst(rst), .s_axis_tdata(s_data), .s_axis_tvalid(s_valid),
    .s_axis_tready(rdy0), .m_axis_tdata(md0), .m_axis_tvalid(mv0),
    .m_axis_tready(m_ready), .m_axis_talmostfull(afull),
    .stat_words(sw0), .stat_overflow(so0));

  nukv_fifo_feeder #(.DATA_SIZE(DW), .PIPE_STAGES(P1), .SLACK(8), .RESUME_CYCLES(R)) u_dut1 (
    .clk(clk), .rst(rst), .s_axis_tdata(s_data), .s_axis_tvalid(s_valid),
    .s_axis_tready(rdy1), .m_axis_tdata(md1), .m_axis_tvalid(mv1),
    .m_axis_tready(m_ready), .m_axis_talmostfull(afull),
    .stat_words(sw1), .stat_overflow(so1));

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s at t=%0t: got %0h, want %0h", name, $time, act, exp);
  endtask

  // Reference model: ready follows the length of the current run of low almost-full
  // samples; writes are scheduled by absolute cycle number.
  int            cyc = 0;
  logic          afq_m = 1'b1;
  int            streak = 0;
  logic          rdy_m = 1'b0;
  logic          ev [2][64];
  logic [DW-1:0] ed [2][64];
  logic [31:0]   words_m [2];
  logic          ovf_m [2];

  function automatic int pipe_of(input int k);
    return (k == 0) ? P0 : P1;
  endfunction

  task automatic model_edge();
    logic acc;
    if (rst) begin
      afq_m = 1'b1; streak = 0; rdy_m = 1'b0;
      for (int k = 0; k < 2; k++) begin
        for (int j = 0; j < 64; j++) ev[k][j] = 1'b0;
        words_m[k] = '0; ovf_m[k] = 1'b0;
      end
      cyc++;
    end else begin
      acc = s_valid && rdy_m;
      for (int k = 0; k < 2; k++) begin
        if (ev[k][cyc % 64]) begin
          if (m_ready) words_m[k] = words_m[k] + 32'd1;
          else         ovf_m[k] = 1'b1;
          ev[k][cyc % 64] = 1'b0;
        end
      end
      cyc++;
      if (acc) begin
        for (int k = 0; k < 2; k++) begin
          ev[k][(cyc + pipe_of(k) - 1) % 64] = 1'b1;
          ed[k][(cyc + pipe_of(k) - 1) % 64] = s_data;
        end
      end
      if (!afq_m) begin
        if (streak < 1000) streak++;
      end else begin
        streak = 0;
      end
      afq_m = afull;
      rdy_m = (streak >= R + 1);
    end
  endtask

  task automatic compare_inst(input int k, input logic rdy, input logic mv,
                              input logic [DW-1:0] md, input logic [31:0] sw, input logic so);
    logic exp_v;
    exp_v = ev[k][cyc % 64];
    check($sformatf("ready[%0d]", k), {31'd0, rdy}, {31'd0, rdy_m});
    check($sformatf("mvalid[%0d]", k), {31'd0, mv}, {31'd0, exp_v});
    if (exp_v) check($sformatf("mdata[%0d]", k), {16'd0, md}, {16'd0, ed[k][cyc % 64]});
`ifdef NUKV_FEEDER_STATS_EN
    check($sformatf("words[%0d]", k), sw, words_m[k]);
    check($sformatf("ovf[%0d]", k), {31'd0, so}, {31'd0, ovf_m[k]});
`else
    check($sformatf("words[%0d]", k), sw, 32'd0);
    check($sformatf("ovf[%0d]", k), {31'd0, so}, 32'd0);
`endif
  endtask

  task automatic step(input logic r, input logic v, input logic [DW-1:0] d,
                      input logic af, input logic mr);
    rst = r; s_valid = v; s_data = d; afull = af; m_ready = mr;
    @(posedge clk);
    model_edge();
    #1;
    compare_inst(0, rdy0, mv0, md0, sw0, so0);
    compare_inst(1, rdy1, mv1, md1, sw1, so1);
  endtask

  typedef struct {
    logic          r, af, v;
    logic [DW-1:0] d;
    logic          exp_rdy, exp_mv;
    logic [DW-1:0] exp_md;
  } vec_t;

  vec_t        tbl [13];
  logic [31:0] sw_base;
  logic        af_rnd;
  int          waited;

  initial begin
    for (int k = 0; k < 2; k++) begin
      for (int j = 0; j < 64; j++) begin ev[k][j] = 1'b0; ed[k][j] = '0; end
      words_m[k] = '0; ovf_m[k] = 1'b0;
    end
    rst = 1'b1; s_valid = 1'b0; s_data = '0; afull = 1'b0; m_ready = 1'b1;

    // Reset release, resume delay, first beats, and almost-full rising mid-stream.
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000};
    for (int i = 1; i <= 5; i++) tbl[i] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000};
    tbl[7]  = '{1'b0, 1'b0, 1'b1, 16'h0001, 1'b1, 1'b1, 16'h0001};
    tbl[8]  = '{1'b0, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b1, 16'h0002};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000};
    tbl[10] = '{1'b0, 1'b1, 1'b1, 16'h0003, 1'b1, 1'b1, 16'h0003};
    tbl[11] = '{1'b0, 1'b1, 1'b1, 16'h0004, 1'b0, 1'b1, 16'h0004};
    tbl[12] = '{1'b0, 1'b1, 1'b1, 16'h0005, 1'b0, 1'b0, 16'h0000};

    for (int i = 0; i < 13; i++) begin
      step(tbl[i].r, tbl[i].v, tbl[i].d, tbl[i].af, 1'b1);
      check($sformatf("tbl_ready#%0d", i), {31'd0, rdy0}, {31'd0, tbl[i].exp_rdy});
      check($sformatf("tbl_mvalid#%0d", i), {31'd0, mv0}, {31'd0, tbl[i].exp_mv});
      if (tbl[i].exp_mv) check($sformatf("tbl_mdata#%0d", i), {16'd0, md0}, {16'd0, tbl[i].exp_md});
      if (i == 0) check("reset_mdata", {16'd0, md0}, 32'd0);
    end

    // Wait (bounded) for RUN, then stream 0x0001..0x0010 back-to-back.
    waited = 0;
    while (!rdy0 && waited < 20) begin step(1'b0, 1'b0, '0, 1'b0, 1'b1); waited++; end
    check("resume_within_bound", {31'd0, rdy0}, 32'd1);
    sw_base = sw0;
    for (int i = 1; i <= 16; i++) begin
      step(1'b0, 1'b1, DW'(i), 1'b0, 1'b1);
      check("stream_mvalid", {31'd0, mv0}, 32'd1);
      check("stream_mdata", {16'd0, md0}, i);
    end
    step(1'b0, 1'b0, '0, 1'b0, 1'b1);
`ifdef NUKV_FEEDER_STATS_EN
    check("stream_words", sw0 - sw_base, 32'd16);
`else
    check("stream_words", sw0, 32'd0);
`endif

    // Hysteresis: enter HOLD, then low, low, high, then lows; ready after the 6th low step.
    step(1'b0, 1'b0, '0, 1'b1, 1'b1);
    step(1'b0, 1'b0, '0, 1'b1, 1'b1);
    for (int s = 1; s <= 10; s++) begin
      step(1'b0, 1'b0, '0, (s == 3), 1'b1);
      check($sformatf("hyst_ready_s%0d", s), {31'd0, rdy0}, {31'd0, (s >= 9)});
    end

    // Overflow: a write issued while the FIFO reports full.
    step(1'b0, 1'b1, 16'hBEEF, 1'b0, 1'b1);
    step(1'b0, 1'b0, '0, 1'b0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0, 1'b1);
    step(1'b0, 1'b0, '0, 1'b0, 1'b1);
`ifdef NUKV_FEEDER_STATS_EN
    check("ovf_sticky", {31'd0, so0}, 32'd1);
`else
    check("ovf_disabled", {31'd0, so0}, 32'd0);
`endif

    // Reset with two beats in flight on the two-stage instance.
    step(1'b0, 1'b1, 16'hA0A0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 16'hB0B0, 1'b0, 1'b1);
    check("inflight_visible", {31'd0, mv1}, 32'd1);
    step(1'b1, 1'b0, '0, 1'b0, 1'b1);
    check("rst_mvalid", {31'd0, mv1}, 32'd0);
    check("rst_mdata", {16'd0, md1}, 32'd0);
    check("rst_ready", {31'd0, rdy1}, 32'd0);
    check("rst_words", sw1, 32'd0);
    check("rst_ovf", {31'd0, so1}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, '0, 1'b0, 1'b1);
      check("post_rst_no_write", {31'd0, mv1}, 32'd0);
    end

    // Randomized traffic against the model.
    af_rnd = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) af_rnd = ~af_rnd;
      step(($urandom_range(0, 299) == 0), ($urandom_range(0, 3) != 0), DW'($urandom),
           af_rnd, ($urandom_range(0, 15) != 0));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
